// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE exception flag bundle and
// default sizing constants for the result reorder buffer.
package fpnew_pkg;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   localparam int unsigned REORDER_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fpnew_result_reorder.sv
// Tag-ordered result collector: slots are allocated in order,
// filled out of order by res_*, and released in order on out_*.
// Ports: clk_i/rst_i (sync, active-high), flush_i; alloc_* grants
// slot IDs; res_* writes a slot; out_* presents the head slot;
// busy_o = any slot allocated; err_o = bad write-back pulse.
// Option: FPNEW_REORDER_BYPASS_EN forwards a head result on
// out_* in the same cycle it arrives.
module fpnew_result_reorder
   import fpnew_pkg::*;
#(
   parameter int unsigned Width   = 32,
   parameter int unsigned Depth   = REORDER_DEFAULT_DEPTH,
   parameter int unsigned IdWidth = $clog2(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               alloc_valid_i,
   output logic               alloc_ready_o,
   output logic [IdWidth-1:0] alloc_id_o,
   input  logic               res_valid_i,
   output logic               res_ready_o,
   input  logic [IdWidth-1:0] res_id_i,
   input  logic [Width-1:0]   res_result_i,
   input  status_t            res_status_i,
   input  logic               res_ext_bit_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [Width-1:0]   out_result_o,
   output status_t            out_status_o,
   output logic               out_ext_bit_o,
   output logic [IdWidth-1:0] out_id_o,
   output logic               busy_o,
   output logic               err_o
);

   typedef struct packed {
      logic [Width-1:0] result;
      status_t          status;
      logic             ext_bit;
   } entry_t;

   entry_t             mem_q [Depth];
   logic [Depth-1:0]   alloc_q, done_q;
   logic [Depth-1:0]   alloc_n, done_n;
   logic [IdWidth:0]   head_q, tail_q;
   logic               err_q;

   logic [IdWidth-1:0] head_idx, tail_idx;
   logic               full, empty;
   logic               alloc_fire, wb_fire, wb_ok, ret_fire;
   logic               head_vld;
   entry_t             head_ent, res_ent;

   assign head_idx = head_q[IdWidth-1:0];
   assign tail_idx = tail_q[IdWidth-1:0];

   assign empty = (head_q == tail_q);
   assign full  = (head_q[IdWidth] != tail_q[IdWidth]) &&
                  (head_idx == tail_idx);

   // Not full is checked against current state only, so a retire
   // in the same cycle never frees a slot for allocation.
   assign alloc_ready_o = ~full & ~flush_i;
   assign alloc_id_o    = tail_idx;
   assign res_ready_o   = ~flush_i;
   assign busy_o        = ~empty;
   assign err_o         = err_q;

   assign alloc_fire = alloc_valid_i & alloc_ready_o;
   assign wb_fire    = res_valid_i & res_ready_o;
   assign wb_ok      = wb_fire & alloc_q[res_id_i] & ~done_q[res_id_i];

   assign res_ent = '{result:  res_result_i,
                      status:  res_status_i,
                      ext_bit: res_ext_bit_i};

`ifdef FPNEW_REORDER_BYPASS_EN
   logic byp;
   assign byp      = wb_ok & (res_id_i == head_idx);
   assign head_vld = done_q[head_idx] | byp;
   assign head_ent = done_q[head_idx] ? mem_q[head_idx] : res_ent;
`else
   assign head_vld = done_q[head_idx];
   assign head_ent = mem_q[head_idx];
`endif

   // Entries are not reset; gate out_* so idle outputs read zero.
   assign out_valid_o   = head_vld;
   assign out_result_o  = head_vld ? head_ent.result  : '0;
   assign out_status_o  = head_vld ? head_ent.status  : '0;
   assign out_ext_bit_o = head_vld ? head_ent.ext_bit : 1'b0;
   assign out_id_o      = head_vld ? head_idx         : '0;

   assign ret_fire = out_valid_o & out_ready_i;

   // Retire is applied last so a bypassed head is freed, not marked.
   always_comb begin
      alloc_n = alloc_q;
      done_n  = done_q;
      if (alloc_fire) begin
         alloc_n[tail_idx] = 1'b1;
         done_n[tail_idx]  = 1'b0;
      end
      if (wb_ok) begin
         done_n[res_id_i] = 1'b1;
      end
      if (ret_fire) begin
         alloc_n[head_idx] = 1'b0;
         done_n[head_idx]  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         alloc_q <= '0;
         done_q  <= '0;
      end else begin
         if (alloc_fire) tail_q <= tail_q + 1'b1;
         if (ret_fire)   head_q <= head_q + 1'b1;
         alloc_q <= alloc_n;
         done_q  <= done_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= wb_fire & ~wb_ok;
   end

   always_ff @(posedge clk_i) begin
      if (wb_ok) mem_q[res_id_i] <= res_ent;
   end

endmodule
